// File: rtl/program_sequencer_pkg.sv
// Shared types and encodings for the program sequencer: FSM states, opcode
// prefixes, reg_en bit positions, data-bus source codes and register codes.
package program_sequencer_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  // Opcode prefixes, compared against the top bits of ir
  localparam logic       OP_LOAD = 1'b0;     // ir[7]
  localparam logic [1:0] OP_MOV  = 2'b10;    // ir[7:6]
  localparam logic [2:0] OP_ALU  = 3'b110;   // ir[7:5]
  localparam logic [3:0] OP_JMP  = 4'hE;     // ir[7:4]
  localparam logic [3:0] OP_JNZ  = 4'hF;     // ir[7:4]

  localparam int EN_X0   = 0;
  localparam int EN_X1   = 1;
  localparam int EN_Y0   = 2;
  localparam int EN_Y1   = 3;
  localparam int EN_R    = 4;
  localparam int EN_M    = 5;
  localparam int EN_I    = 6;
  localparam int EN_DM   = 7;
  localparam int EN_OREG = 8;

  localparam logic [3:0] SRC_X0    = 4'd0;
  localparam logic [3:0] SRC_X1    = 4'd1;
  localparam logic [3:0] SRC_Y0    = 4'd2;
  localparam logic [3:0] SRC_Y1    = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_M     = 4'd5;
  localparam logic [3:0] SRC_I     = 4'd6;
  localparam logic [3:0] SRC_DM    = 4'd7;
  localparam logic [3:0] SRC_IMM   = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;
  localparam logic [3:0] SRC_NONE  = 4'hF;

  localparam logic [2:0] RC_X0   = 3'd0;
  localparam logic [2:0] RC_X1   = 3'd1;
  localparam logic [2:0] RC_Y0   = 3'd2;
  localparam logic [2:0] RC_Y1   = 3'd3;
  localparam logic [2:0] RC_OREG = 3'd4;
  localparam logic [2:0] RC_M    = 3'd5;
  localparam logic [2:0] RC_I    = 3'd6;
  localparam logic [2:0] RC_DM   = 3'd7;

  function automatic logic [8:0] dst_enable(input logic [2:0] code);
    logic [8:0] en;
    en = '0;
    case (code)
      RC_X0:   en[EN_X0]   = 1'b1;
      RC_X1:   en[EN_X1]   = 1'b1;
      RC_Y0:   en[EN_Y0]   = 1'b1;
      RC_Y1:   en[EN_Y1]   = 1'b1;
      RC_OREG: en[EN_OREG] = 1'b1;
      RC_M:    en[EN_M]    = 1'b1;
      RC_I:    en[EN_I]    = 1'b1;
      default: en[EN_DM]   = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/program_sequencer_instr_decoder.sv
// Combinational instruction decode: ir to bus source, register enables,
// i-pointer mode and jump flags. Gating by FSM state is done in the top.
module instr_decoder
  import program_sequencer_pkg::*;
(
  input  logic [7:0] i_ir,
  output logic [3:0] o_source_sel,
  output logic [8:0] o_reg_en,
  output logic       o_i_sel,
  output logic       o_jmp,
  output logic       o_jnz
);

  logic [2:0] w_dst;
  logic       w_xfer;
  logic       w_src_dm;

  always_comb begin
    o_source_sel = SRC_NONE;
    o_reg_en     = '0;
    o_i_sel      = 1'b0;
    o_jmp        = 1'b0;
    o_jnz        = 1'b0;
    w_dst        = RC_X0;
    w_xfer       = 1'b0;
    w_src_dm     = 1'b0;

    if (i_ir[7] == OP_LOAD) begin
      w_xfer       = 1'b1;
      w_dst        = i_ir[6:4];
      o_source_sel = SRC_IMM;
    end else if (i_ir[7:6] == OP_MOV) begin
      w_xfer   = 1'b1;
      w_dst    = i_ir[5:3];
      w_src_dm = (i_ir[2:0] == RC_DM);
      // Register codes 0..7 coincide with bus codes 0..7 (code 4 reads r)
      o_source_sel = (i_ir[2:0] == i_ir[5:3]) ? SRC_IPINS : {1'b0, i_ir[2:0]};
    end else if (i_ir[7:5] == OP_ALU) begin
      o_reg_en[EN_R] = 1'b1;
    end else if (i_ir[7:4] == OP_JMP) begin
      o_jmp = 1'b1;
    end else begin
      o_jnz = 1'b1;
    end

    if (w_xfer) begin
      o_reg_en = dst_enable(w_dst);
      // Any dm access bumps i by m, unless i itself is being loaded from dm
      if (w_dst == RC_DM || w_src_dm) begin
        o_reg_en[EN_I] = 1'b1;
        o_i_sel        = (w_dst != RC_I);
      end
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Two-cycle fetch/execute sequencer: owns pc and ir, drives program-memory
// address and the decoded datapath control bundle.
//
// state   | meaning
// S_RESET | one cycle after reset release; sync_reset asserted, bus idle
// S_FETCH | ir <= pm_data, pc <= pc+1 on the closing edge
// S_EXEC  | decoded controls asserted; jumps load pc on the closing edge
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [7:0]          i_pm_data,
  input  logic                i_r_eq_0,
  output logic [PC_WIDTH-1:0] o_pm_address,
  output logic [7:0]          o_ir,
  output logic [3:0]          o_nibble_ir,
  output logic                o_x_sel,
  output logic                o_y_sel,
  output logic                o_i_sel,
  output logic [3:0]          o_source_sel,
  output logic [8:0]          o_reg_en,
  output logic                o_dm_we,
  output logic                o_sync_reset
);

  state_e              r_state;
  state_e              w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_target;
  logic [7:0]          r_ir;
  logic [3:0]          w_dec_src;
  logic [8:0]          w_dec_en;
  logic                w_dec_isel;
  logic                w_jmp;
  logic                w_jnz;
  logic                w_take;

  instr_decoder u_dec (
    .i_ir         (r_ir),
    .o_source_sel (w_dec_src),
    .o_reg_en     (w_dec_en),
    .o_i_sel      (w_dec_isel),
    .o_jmp        (w_jmp),
    .o_jnz        (w_jnz)
  );

  assign w_pc_inc = r_pc + PC_WIDTH'(1);
  assign w_target = PC_WIDTH'({r_ir[3:0], 4'h0});
  assign w_take   = (r_state == S_EXEC) && (w_jmp || (w_jnz && !i_r_eq_0));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_RESET;
      r_pc    <= RESET_VECTOR;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_ir <= i_pm_data;
        r_pc <= w_pc_inc;
      end else if (w_take) begin
        r_pc <= w_target;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    o_reg_en     = '0;
    o_source_sel = SRC_NONE;
    o_i_sel      = 1'b0;
    o_sync_reset = 1'b0;
    case (r_state)
      S_RESET: begin
        w_next       = S_FETCH;
        o_sync_reset = 1'b1;
      end
      S_FETCH: w_next = S_EXEC;
      S_EXEC: begin
        w_next       = S_FETCH;
        o_reg_en     = w_dec_en;
        o_source_sel = w_dec_src;
        o_i_sel      = w_dec_isel;
      end
      default: w_next = S_RESET;
    endcase
  end

  // The ROM registers its address, so a taken jump presents its target during
  // EXEC; the word is then ready when the following FETCH samples pm_data.
  assign o_pm_address = w_take ? w_target : r_pc;
  assign o_ir         = r_ir;
  assign o_nibble_ir  = r_ir[3:0];
  assign o_x_sel      = r_ir[4];
  assign o_y_sel      = r_ir[3];
  assign o_dm_we      = o_reg_en[EN_DM];

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: synchronous ROM model, directed program
// through the listed cases, then a random program against a reference model.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pm_data;
  logic       r_eq_0 = 1'b0;
  logic [7:0] pm_address;
  logic [7:0] ir;
  logic [3:0] nibble_ir;
  logic       x_sel, y_sel, i_sel, dm_we, sync_reset;
  logic [3:0] source_sel;
  logic [8:0] reg_en;

  program_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_pm_data    (pm_data),
    .i_r_eq_0     (r_eq_0),
    .o_pm_address (pm_address),
    .o_ir         (ir),
    .o_nibble_ir  (nibble_ir),
    .o_x_sel      (x_sel),
    .o_y_sel      (y_sel),
    .o_i_sel      (i_sel),
    .o_source_sel (source_sel),
    .o_reg_en     (reg_en),
    .o_dm_we      (dm_we),
    .o_sync_reset (sync_reset)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) pm_data <= mem[pm_address];

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_pc;
  logic [7:0] last_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference decode: which register each 3-bit code writes, then the dm rule
  function automatic void ref_decode(input logic [7:0] op, output logic [3:0] ss,
                                     output logic [8:0] en, output logic isel);
    int  en_bit [8] = '{0, 1, 2, 3, 8, 5, 6, 7};
    int  dst, src;
    bit  xfer;
    ss = 4'hF; en = '0; isel = 1'b0; xfer = 0; src = -1; dst = 0;
    if (op[7] == 1'b0) begin
      xfer = 1; dst = int'(op[6:4]); ss = 4'd8;
    end else if (op[7:6] == 2'b10) begin
      xfer = 1; dst = int'(op[5:3]); src = int'(op[2:0]);
      ss = (src == dst) ? 4'd9 : 4'(src);
    end else if (op[7:5] == 3'b110) begin
      en = 9'h010;
    end
    if (xfer) begin
      en = 9'(1 << en_bit[dst]);
      if (dst == 7 || src == 7) begin
        en   = en | 9'h040;
        isel = (dst != 6);
      end
    end
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sync", sync_reset, 1);
    chk("rst_en", reg_en, 0);
    chk("rst_src", source_sel, 4'hF);
    chk("rst_pc", pm_address, 8'h00);
    chk("rst_ir", ir, 8'h00);
    reset_n = 1'b1;
    #1;
    chk("rel_sync", sync_reset, 1);
    chk("rel_en", reg_en, 0);
    @(posedge clk);
    #1;
    m_pc    = 8'h00;
    last_ir = 8'h00;
  endtask

  // Entered #1 after the edge that opens FETCH; leaves at the next FETCH.
  task automatic step_instr(input logic r0);
    logic [7:0] op;
    logic [3:0] ss;
    logic [8:0] en;
    logic       isel;
    r_eq_0 = r0;
    chk("fetch_pc", pm_address, m_pc);
    chk("fetch_en", reg_en, 0);
    chk("fetch_src", source_sel, 4'hF);
    chk("fetch_isel", i_sel, 0);
    chk("fetch_dmwe", dm_we, 0);
    chk("fetch_sync", sync_reset, 0);
    chk("fetch_nib", nibble_ir, last_ir[3:0]);
    @(posedge clk);
    #1;
    op = mem[m_pc];
    ref_decode(op, ss, en, isel);
    chk("exec_ir", ir, op);
    chk("exec_nib", nibble_ir, op[3:0]);
    chk("exec_xsel", x_sel, op[4]);
    chk("exec_ysel", y_sel, op[3]);
    chk("exec_src", source_sel, ss);
    chk("exec_en", reg_en, en);
    chk("exec_dmwe", dm_we, en[7]);
    chk("exec_isel", i_sel, isel);
    chk("exec_sync", sync_reset, 0);
    if (op[7:4] == 4'hE || (op[7:4] == 4'hF && !r0)) m_pc = {op[3:0], 4'h0};
    else                                              m_pc = m_pc + 8'd1;
    last_ir = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[8'h00] = 8'h1A; mem[8'h01] = 8'h97; mem[8'h02] = 8'hB7;
    mem[8'h03] = 8'hA4; mem[8'h04] = 8'hD2; mem[8'h05] = 8'hE3;
    mem[8'h30] = 8'hF5; mem[8'h31] = 8'hF5; mem[8'h50] = 8'hEF;
    for (int a = 8'hF0; a < 256; a++) begin
      v = 8'($urandom);
      if (v[7:5] == 3'b111) v[7] = 1'b0;
      mem[a] = v;
    end

    do_reset();
    for (int k = 0; k < 6; k++) step_instr(1'($urandom));
    chk("jmp_target", pm_address, 8'h30);
    step_instr(1'b1);
    chk("jnz_not_taken", pm_address, 8'h31);
    step_instr(1'b0);
    chk("jnz_taken", pm_address, 8'h50);
    step_instr(1'($urandom));
    for (int k = 0; k < 16; k++) step_instr(1'($urandom));
    chk("pc_wrap", pm_address, 8'h00);

    reset_n = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    do_reset();
    for (int k = 0; k < 300; k++) step_instr(1'($urandom_range(0, 1)));

    mem[8'h00] = 8'h1A;
    do_reset();
    @(posedge clk);
    #1;
    chk("mid_exec_en", reg_en, 9'h002);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_en", reg_en, 0);
    chk("abort_pc", pm_address, 8'h00);
    chk("abort_sync", sync_reset, 1);
    chk("abort_ir", ir, 8'h00);
    do_reset();
    for (int k = 0; k < 4; k++) step_instr(1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
